// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the icache/dcache memory arbiter.
// slave = arbiter view; master = caches plus memory model view.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256
);
  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic [BLOCK_W-1:0] i_rdata;
  logic               i_ack;

  logic               d_req;
  logic               d_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_wdata;
  logic [BLOCK_W-1:0] d_rdata;
  logic               d_ack;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one block memory between icache and dcache: grant, MEM_LAT strobe cycles, 1-cycle ack.
// Requesters hold req until ack; dcache wins ties unless ARB_ROUND_ROBIN_EN alternates them.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic              own_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } xfer_t;

  state_t             state_q;
  state_t             state_d;
  xfer_t              xfer_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [BLOCK_W-1:0] i_rdata_q;
  logic [BLOCK_W-1:0] d_rdata_q;
  logic               start;
  logic               last_beat;
  logic               pick_d;
  logic [ADDR_W-1:0]  sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
  // Last granted owner; starts as icache so the first tie goes to dcache.
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (start) begin
      last_d_q <= pick_d;
    end
  end

  assign pick_d = bus.d_req && (!bus.i_req || !last_d_q);
`else
  assign pick_d = bus.d_req;
`endif

  assign sel_addr = pick_d ? bus.d_addr : bus.i_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    last_beat   = 1'b0;
    bus.mem_re  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.i_ack   = 1'b0;
    bus.d_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          start   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.mem_re = !xfer_q.we;
        bus.mem_we = xfer_q.we;
        if (cnt_q == CNT_LAST) begin
          last_beat = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        bus.i_ack = !xfer_q.own_d;
        bus.d_ack = xfer_q.own_d;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched at grant so later changes on the cache side are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q    <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (start) begin
        xfer_q.own_d <= pick_d;
        xfer_q.we    <= pick_d && bus.d_we;
        xfer_q.addr  <= sel_addr & ~ADDR_W'(32'h1F);
        if (pick_d && bus.d_we) begin
          wdata_q <= bus.d_wdata;
        end
      end
      if (state_q == BUSY) begin
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
      if (last_beat && !xfer_q.we) begin
        if (xfer_q.own_d) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          i_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = xfer_q.addr;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level grant model feeds an expected queue, monitor checks.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int BW  = 256;
  localparam int LAT = 4;

  typedef struct {
    bit          own_d;
    bit          we;
    logic [31:0] addr;
    logic [BW-1:0] wdata;
    int          g;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int free_at = 0;
  bit last_d = 1'b0;
  bit i_gnt_flag = 1'b0;
  bit d_gnt_flag = 1'b0;
  txn_t q[$];
  logic [BW-1:0] exp_i = '0;
  logic [BW-1:0] exp_d = '0;
  logic [BW-1:0] ref_mem [logic [31:0]];
  logic [BW-1:0] env_mem [logic [31:0]];

  function automatic logic [BW-1:0] pat(input logic [31:0] a);
    logic [BW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = a ^ (32'h9E37_0000 + 32'(k));
    return r;
  endfunction

  function automatic logic [BW-1:0] junk();
    logic [BW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [BW-1:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic logic [BW-1:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : pat(a);
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the arbiter is free again LAT+2 edges after a grant; dcache wins ties.
  initial begin
    txn_t t;
    bit take_d;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        free_at = cyc + 1;
        exp_i = '0;
        exp_d = '0;
        last_d = 1'b0;
      end else if (cyc >= free_at && (bus.i_req || bus.d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        take_d = bus.d_req && (!bus.i_req || !last_d);
`else
        take_d = bus.d_req;
`endif
        t.own_d = take_d;
        t.we    = take_d && bus.d_we;
        t.addr  = (take_d ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFE0;
        t.wdata = bus.d_wdata;
        t.g     = cyc;
        q.push_back(t);
        free_at = cyc + LAT + 2;
        last_d  = take_d;
        if (take_d) d_gnt_flag = 1'b1;
        else        i_gnt_flag = 1'b1;
      end
    end
  end

  // Memory model: read data is only valid in the last strobe cycle, junk before it.
  initial begin
    int rrun;
    int wrun;
    rrun = 0;
    wrun = 0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_re === 1'b1) rrun++;
      else rrun = 0;
      if (bus.mem_we === 1'b1) begin
        wrun++;
        if (wrun == LAT) env_mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        wrun = 0;
      end
      bus.mem_rdata = (rrun == LAT) ? env_rd(bus.mem_addr) : junk();
    end
  end

  // Monitor: every cycle compares strobes/acks, address, write data and both rdata buses.
  initial begin
    txn_t t;
    logic [3:0] ec;
    logic [3:0] ac;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ec = 4'b0000;
      if (q.size() > 0) begin
        t = q[0];
        if (cyc >= t.g && cyc < t.g + LAT) begin
          ec = t.we ? 4'b0001 : 4'b0010;
          chk("mem_addr", BW'(bus.mem_addr), BW'(t.addr));
          if (t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
        end else if (cyc == t.g + LAT) begin
          ec = t.own_d ? 4'b0100 : 4'b1000;
          if (!t.own_d)   exp_i = ref_rd(t.addr);
          else if (!t.we) exp_d = ref_rd(t.addr);
          else            ref_mem[t.addr] = t.wdata;
          void'(q.pop_front());
        end
      end
      ac = {bus.i_ack, bus.d_ack, bus.mem_re, bus.mem_we};
      chk("ack_strobe", BW'(ac), BW'(ec));
      chk("i_rdata", bus.i_rdata, exp_i);
      chk("d_rdata", bus.d_rdata, exp_d);
    end
  end

  task automatic wait_ack(input bit is_d, input bit scramble, input bit drop_early);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (is_d ? d_gnt_flag : i_gnt_flag) begin
        if (is_d) d_gnt_flag = 1'b0;
        else      i_gnt_flag = 1'b0;
        if (scramble) begin
          if (is_d) begin
            bus.d_addr  = $urandom;
            bus.d_wdata = junk();
          end else begin
            bus.i_addr = $urandom;
          end
        end
        if (drop_early) begin
          if (is_d) bus.d_req = 1'b0;
          else      bus.i_req = 1'b0;
        end
      end
      if (is_d ? bus.d_ack : bus.i_ack) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_ack_timeout got=0 want=1 cyc=%0d", is_d ? "d" : "i", cyc);
    end
    @(posedge clk);
    #1;
    if (is_d) bus.d_req = 1'b0;
    else      bus.i_req = 1'b0;
  endtask

  task automatic do_i(input logic [31:0] addr, input bit scr, input bit drop);
    bus.i_addr = addr;
    bus.i_req  = 1'b1;
    wait_ack(1'b0, scr, drop);
  endtask

  task automatic do_d(input bit we, input logic [31:0] addr, input logic [BW-1:0] wdata,
                      input bit scr, input bit drop);
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    wait_ack(1'b1, scr, drop);
  endtask

  initial begin
    logic [BW-1:0] a5;
    logic [BW-1:0] ones;
    a5   = {32{8'hA5}};
    ones = {32{8'h11}};
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    env_mem[32'h0000_1220] = a5;
    ref_mem[32'h0000_1220] = a5;

    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", BW'(bus.mem_addr), '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // icache fill of an unaligned address
    do_i(32'h0000_1234, 1'b0, 1'b0);
    chk("t1_i_rdata", bus.i_rdata, a5);

    // dcache write-back
    do_d(1'b1, 32'h0000_0040, ones, 1'b0, 1'b0);

    // simultaneous requests, repeated
    repeat (3) begin
      fork
        do_d(1'b0, 32'h0000_0100, '0, 1'b0, 1'b0);
        do_i(32'h0000_0080, 1'b0, 1'b0);
      join
    end

    // reset in the second BUSY cycle aborts the read; re-request completes
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0200;
    bus.d_req  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    d_gnt_flag = 1'b0;
    do_d(1'b0, 32'h0000_0200, '0, 1'b0, 1'b0);

    // random concurrent traffic with back-to-back requests, mid-transfer changes and early drops
    fork
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        do_i(32'($urandom_range(0, 32'hFFFF)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      end
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
        do_d(bit'($urandom_range(0, 1)),
             32'h0001_0000 + 32'($urandom_range(0, 7) << 5) + 32'($urandom_range(0, 31)),
             junk(), bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("end_queue_empty", BW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
